// File: rtl/jtpang_objdma_if.sv
// jtpang_objdma_if: handshake and bus signals between the object DMA and the main board
// Signals:
//   cen              DMA clock enable
//   dma_go           CPU I/O strobe, rising edge starts a transfer
//   busrq_n/busak_n  Z80 bus request / acknowledge, active low
//   src_addr/src_cs  CPU video RAM read address / enable, src_dout read data
//   obj_addr/obj_din object buffer write address / data, obj_we write strobe
//   busy             transfer in progress
// Modports: master = DMA engine, slave = surrounding board
interface jtpang_objdma_if #(
    parameter int AW = 9
);
    logic          cen;
    logic          dma_go;
    logic          busrq_n;
    logic          busak_n;
    logic [11:0]   src_addr;
    logic          src_cs;
    logic [7:0]    src_dout;
    logic [AW-1:0] obj_addr;
    logic [7:0]    obj_din;
    logic          obj_we;
    logic          busy;
    modport master (
        input  cen, dma_go, busak_n, src_dout,
        output busrq_n, src_addr, src_cs, obj_addr, obj_din, obj_we, busy
    );
    modport slave (
        output cen, dma_go, busak_n, src_dout,
        input  busrq_n, src_addr, src_cs, obj_addr, obj_din, obj_we, busy
    );
endinterface

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: copies the object attribute table from CPU video RAM into the object buffer
// Ports:
//   clk   system clock
//   rst_n asynchronous active-low reset
//   bus   jtpang_objdma_if.master: cen, dma_go, bus request/ack, source read port,
//         object buffer write port, busy
module jtpang_objdma #(
    parameter int          AW       = 9,
    parameter logic [11:0] SRC_BASE = 12'h000
) (
    input logic             clk,
    input logic             rst_n,
    jtpang_objdma_if.master bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RD, ST_WR, ST_REL} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_obj_addr;
    logic [7:0]    r_obj_din;
    logic          r_go_d;
    logic          r_trig;
    logic          w_rise;
    logic          w_ak_cen;
    logic          w_start;
    logic          w_wr;

    assign w_rise   = bus.dma_go & ~r_go_d;
    assign w_ak_cen = bus.cen & ~bus.busak_n;
    assign w_start  = (r_state == ST_IDLE) & bus.cen & r_trig;
    assign w_wr     = (r_state == ST_WR) & w_ak_cen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // RD/WR only advance while the bus is granted, so a lost grant freezes the copy
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start)  w_next = ST_REQ;
            ST_REQ:  if (w_ak_cen) w_next = ST_RD;
            ST_RD:   if (w_ak_cen) w_next = ST_WR;
            ST_WR:   if (w_ak_cen) w_next = &r_idx ? ST_REL : ST_RD;
            ST_REL:  if (bus.cen)  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // r_go_d resets high so a dma_go level already present at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go_d     <= 1'b1;
            r_trig     <= 1'b0;
            r_idx      <= '0;
            r_obj_addr <= '0;
            r_obj_din  <= 8'h00;
        end else begin
            r_go_d <= bus.dma_go;
            if (w_start)                          r_trig <= 1'b0;
            else if (w_rise && r_state == ST_IDLE) r_trig <= 1'b1;
            if (w_start) begin
                r_idx <= '0;
            end else if (w_wr) begin
                r_idx      <= r_idx + 1'b1;
                r_obj_addr <= r_idx;
                r_obj_din  <= bus.src_dout;
            end
        end
    end

    // During WR the live index and read data drive the buffer so they are valid on the
    // strobe clk; the registered copies keep them stable until the next WR.
    always_comb begin
        bus.busrq_n  = !(r_state inside {ST_REQ, ST_RD, ST_WR});
        bus.busy     = r_state != ST_IDLE;
        bus.src_cs   = r_state inside {ST_RD, ST_WR};
        bus.src_addr = SRC_BASE + 12'(r_idx);
        bus.obj_we   = w_wr;
        bus.obj_addr = r_state == ST_WR ? r_idx : r_obj_addr;
        bus.obj_din  = r_state == ST_WR ? bus.src_dout : r_obj_din;
    end
endmodule

// File: tb/tb_jtpang_objdma.sv
// tb_jtpang_objdma: directed bench for jtpang_objdma (base 000 and base F00 instances)
module tb_jtpang_objdma;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen   = 1'b0;
    logic        go    = 1'b0;
    logic        stall = 1'b0;
    logic        ak_n  = 1'b1;
    logic [1:0]  akc   = 2'd0;
    logic [7:0]  rd0   = 8'h00;
    logic [7:0]  rd1   = 8'h00;
    logic [7:0]  mem   [4096];
    logic [7:0]  obuf0 [512];
    logic [7:0]  obuf1 [512];
    int          tag0  [512];
    int          tag1  [512];
    logic [11:0] sa1   [512];
    logic [8:0]  nxt     = 9'd0;
    logic        prev_rq = 1'b1;
    int epoch = 0, cen_cnt = 0, wr_cnt = 0, req_cnt = 0, last_we = -1;
    int bad_we = 0, seq_bad = 0, bad0 = 0, bad1 = 0;
    int errors = 0, checks = 0;

    jtpang_objdma_if #(.AW(9)) ifa ();
    jtpang_objdma_if #(.AW(9)) ifb ();

    assign ifa.cen      = cen;
    assign ifb.cen      = cen;
    assign ifa.dma_go   = go;
    assign ifb.dma_go   = go;
    assign ifa.busak_n  = ak_n | stall;
    assign ifb.busak_n  = ak_n | stall;
    assign ifa.src_dout = rd0;
    assign ifb.src_dout = rd1;

    jtpang_objdma #(.AW(9), .SRC_BASE(12'h000)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifa));
    jtpang_objdma #(.AW(9), .SRC_BASE(12'hF00)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (7) @(negedge clk);
            cen = 1'b1;
            @(negedge clk);
            cen = 1'b0;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Board models: source RAM, Z80 acknowledging 3 cen after request, buffer RAM + monitors
    always @(posedge clk) begin
        if (cen) begin
            cen_cnt <= cen_cnt + 1;
            if (ifa.busrq_n) begin
                akc  <= 2'd0;
                ak_n <= 1'b1;
            end else if (akc < 2'd2) akc <= akc + 2'd1;
            else ak_n <= 1'b0;
            if (ifa.src_cs) rd0 <= mem[ifa.src_addr];
            if (ifb.src_cs) rd1 <= mem[ifb.src_addr];
        end
        prev_rq <= ifa.busrq_n;
        if (prev_rq && !ifa.busrq_n) req_cnt <= req_cnt + 1;
        if (ifa.obj_we) begin
            obuf0[ifa.obj_addr] <= ifa.obj_din;
            tag0[ifa.obj_addr]  <= epoch;
            wr_cnt  <= wr_cnt + 1;
            last_we <= cen_cnt;
            nxt     <= ifa.obj_addr + 9'd1;
            if (!cen) bad_we <= bad_we + 1;
            if (ifa.obj_addr != nxt && ifa.obj_addr != 9'd0) seq_bad <= seq_bad + 1;
            if (ifa.src_addr != 12'(ifa.obj_addr)) bad0 <= bad0 + 1;
        end
        if (ifb.obj_we) begin
            obuf1[ifb.obj_addr] <= ifb.obj_din;
            tag1[ifb.obj_addr]  <= epoch;
            sa1[ifb.obj_addr]   <= ifb.src_addr;
        end
        if (ifb.obj_we != ifa.obj_we ||
            (ifb.obj_we && (ifb.src_addr != 12'hF00 + 12'(ifb.obj_addr) || ifb.obj_addr != ifa.obj_addr)))
            bad1 <= bad1 + 1;
    end

    function automatic int buf_errs(input bit b, input logic [7:0] pat);
        int n = 0;
        for (int i = 0; i < 512; i++) begin
            if (b ? (tag1[i] != epoch || obuf1[i] !== (8'(12'hF00 + 12'(i)) ^ pat))
                  : (tag0[i] != epoch || obuf0[i] !== (8'(i) ^ pat))) n++;
        end
        return n;
    endfunction

    task automatic tick;
        @(posedge clk);
        while (!cen) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] pat);
        for (int a = 0; a < 4096; a++) mem[a] = 8'(a) ^ pat;
        epoch++;
    endtask

    task automatic start(input bit hold, output int lat);
        go  = 1'b1;
        lat = 0;
        while (ifa.busrq_n && lat < 10) begin
            tick;
            lat++;
        end
        if (!hold) go = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        for (int k = 0; k < 1300 && wr_cnt < target; k++) tick;
    endtask

    task automatic wait_done(input int w0, output int t_rq, output int t_idle);
        t_rq   = -1;
        t_idle = -1;
        for (int k = 0; k < 1300 && t_idle < 0; k++) begin
            tick;
            if (t_rq < 0 && wr_cnt - w0 >= 512 && ifa.busrq_n) t_rq = cen_cnt;
            if (t_rq >= 0 && !ifa.busy) t_idle = cen_cnt;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ifa.busrq_n !== 1'b1) begin errors++; $display("FAIL reset_busrq_n: got %b want 1", ifa.busrq_n); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
        checks++; if (ifa.src_cs !== 1'b0 || ifa.obj_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: src_cs=%b obj_we=%b want 0 0", ifa.src_cs, ifa.obj_we); end
        checks++; if (ifa.src_addr !== 12'h000) begin errors++; $display("FAIL reset_src_addr: got %h want 000", ifa.src_addr); end
        checks++; if (ifb.src_addr !== 12'hF00) begin errors++; $display("FAIL reset_src_addr_base: got %h want f00", ifb.src_addr); end
        checks++; if (ifa.obj_addr !== 9'd0 || ifa.obj_din !== 8'h00) begin errors++; $display("FAIL reset_obj: addr=%0d din=%h want 0 00", ifa.obj_addr, ifa.obj_din); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick;
        checks++; if (ifa.busy !== 1'b0 || ifa.busrq_n !== 1'b1) begin errors++; $display("FAIL reset_idle_after: busy=%b busrq_n=%b want 0 1", ifa.busy, ifa.busrq_n); end
    endtask

    task automatic test_basic_copy;
        int w0, r0, lat, t_rq, t_idle, be, sb, b0;
        fill(8'h5A);
        w0 = wr_cnt; r0 = req_cnt; be = bad_we; sb = seq_bad; b0 = bad0;
        start(1'b0, lat);
        checks++; if (lat < 1 || lat > 2) begin errors++; $display("FAIL basic_req_latency: got %0d cen want 1..2", lat); end
        wait_done(w0, t_rq, t_idle);
        checks++; if (t_idle < 0) begin errors++; $display("FAIL basic_done: transfer did not finish, writes=%0d want 512", wr_cnt - w0); end
        checks++; if (wr_cnt - w0 != 512) begin errors++; $display("FAIL basic_writes: got %0d want 512", wr_cnt - w0); end
        checks++; if (t_rq != last_we + 1) begin errors++; $display("FAIL basic_release_timing: busrq_n high at cen %0d want %0d", t_rq, last_we + 1); end
        checks++; if (t_idle != t_rq + 1) begin errors++; $display("FAIL basic_busy_timing: busy low at cen %0d want %0d", t_idle, t_rq + 1); end
        checks++; if (buf_errs(1'b0, 8'h5A) != 0) begin errors++; $display("FAIL basic_buffer: %0d bad bytes want 0", buf_errs(1'b0, 8'h5A)); end
        checks++; if (bad_we != be || seq_bad != sb || bad0 != b0) begin errors++; $display("FAIL basic_write_seq: we_off_cen=%0d addr_seq=%0d src_addr=%0d want 0 0 0", bad_we - be, seq_bad - sb, bad0 - b0); end
        checks++; if (req_cnt - r0 != 1) begin errors++; $display("FAIL basic_requests: got %0d want 1", req_cnt - r0); end
    endtask

    task automatic test_offset_wrap;
        int w0, lat, t_rq, t_idle, b1;
        fill(8'hC3);
        w0 = wr_cnt; b1 = bad1;
        start(1'b0, lat);
        wait_done(w0, t_rq, t_idle);
        checks++; if (bad1 != b1) begin errors++; $display("FAIL wrap_addr_seq: %0d bad writes want 0", bad1 - b1); end
        checks++; if (sa1[0] !== 12'hF00 || sa1[255] !== 12'hFFF) begin errors++; $display("FAIL wrap_src_first: got %h..%h want f00..fff", sa1[0], sa1[255]); end
        checks++; if (sa1[256] !== 12'h000 || sa1[511] !== 12'h0FF) begin errors++; $display("FAIL wrap_src_second: got %h..%h want 000..0ff", sa1[256], sa1[511]); end
        checks++; if (buf_errs(1'b1, 8'hC3) != 0) begin errors++; $display("FAIL wrap_buffer: %0d bad bytes want 0", buf_errs(1'b1, 8'hC3)); end
    endtask

    task automatic test_retrigger;
        int w0, r0, lat, t_rq, t_idle;
        fill(8'h33);
        w0 = wr_cnt; r0 = req_cnt;
        start(1'b0, lat);
        wait_writes(w0 + 100);
        go = 1'b1;
        repeat (4) tick;
        go = 1'b0;
        wait_done(w0, t_rq, t_idle);
        checks++; if (wr_cnt - w0 != 512) begin errors++; $display("FAIL retrig_writes: got %0d want 512", wr_cnt - w0); end
        repeat (50) tick;
        checks++; if (req_cnt - r0 != 1 || ifa.busy !== 1'b0) begin errors++; $display("FAIL retrig_requests: got %0d busy=%b want 1 0", req_cnt - r0, ifa.busy); end
        checks++; if (buf_errs(1'b0, 8'h33) != 0) begin errors++; $display("FAIL retrig_buffer: %0d bad bytes want 0", buf_errs(1'b0, 8'h33)); end
    endtask

    task automatic test_bus_stall;
        int w0, lat, t_rq, t_idle, rq_bad, idx_bad;
        fill(8'hA5);
        w0 = wr_cnt; rq_bad = 0; idx_bad = 0;
        start(1'b0, lat);
        wait_writes(w0 + 200);
        stall = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            if (ifa.busrq_n !== 1'b0) rq_bad++;
            if (ifa.src_addr !== 12'd200) idx_bad++;
        end
        checks++; if (wr_cnt - w0 != 200) begin errors++; $display("FAIL stall_no_writes: got %0d writes want 200", wr_cnt - w0); end
        checks++; if (rq_bad != 0) begin errors++; $display("FAIL stall_busrq_n: high on %0d cen want 0", rq_bad); end
        checks++; if (idx_bad != 0) begin errors++; $display("FAIL stall_index: moved on %0d cen want index 200 held", idx_bad); end
        stall = 1'b0;
        wait_done(w0, t_rq, t_idle);
        checks++; if (wr_cnt - w0 != 512 || t_idle < 0) begin errors++; $display("FAIL stall_writes: got %0d want 512", wr_cnt - w0); end
        checks++; if (buf_errs(1'b0, 8'hA5) != 0) begin errors++; $display("FAIL stall_buffer: %0d bad bytes want 0", buf_errs(1'b0, 8'hA5)); end
    endtask

    task automatic test_reset_mid;
        int w0, r1, w1, lat, act;
        fill(8'h96);
        w0 = wr_cnt; act = 0;
        start(1'b0, lat);
        wait_writes(w0 + 300);
        rst_n = 1'b0;
        #1;
        checks++; if (ifa.busrq_n !== 1'b1 || ifa.busy !== 1'b0) begin errors++; $display("FAIL rstmid_bus: busrq_n=%b busy=%b want 1 0", ifa.busrq_n, ifa.busy); end
        checks++; if (ifa.obj_we !== 1'b0 || ifa.src_cs !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: obj_we=%b src_cs=%b want 0 0", ifa.obj_we, ifa.src_cs); end
        checks++; if (ifa.src_addr !== 12'h000 || ifa.obj_addr !== 9'd0 || ifa.obj_din !== 8'h00) begin errors++; $display("FAIL rstmid_regs: src=%h addr=%0d din=%h want 000 0 00", ifa.src_addr, ifa.obj_addr, ifa.obj_din); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w1 = wr_cnt; r1 = req_cnt;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (ifa.busy !== 1'b0 || ifa.busrq_n !== 1'b1) act++;
        end
        checks++; if (act != 0 || wr_cnt != w1 || req_cnt != r1) begin errors++; $display("FAIL rstmid_quiet: busy cen=%0d writes=%0d req=%0d want 0 0 0", act, wr_cnt - w1, req_cnt - r1); end
    endtask

    task automatic test_level_held;
        int w0, r0, lat;
        fill(8'h0F);
        w0 = wr_cnt; r0 = req_cnt;
        start(1'b1, lat);
        for (int k = lat; k < 2000; k++) tick;
        go = 1'b0;
        repeat (5) tick;
        checks++; if (req_cnt - r0 != 1) begin errors++; $display("FAIL level_requests: got %0d want 1", req_cnt - r0); end
        checks++; if (wr_cnt - w0 != 512 || ifa.busy !== 1'b0) begin errors++; $display("FAIL level_writes: got %0d busy=%b want 512 0", wr_cnt - w0, ifa.busy); end
        checks++; if (buf_errs(1'b0, 8'h0F) != 0) begin errors++; $display("FAIL level_buffer: %0d bad bytes want 0", buf_errs(1'b0, 8'h0F)); end
    endtask

    initial begin
        test_reset;
        test_basic_copy;
        test_offset_wrap;
        test_retrigger;
        test_bus_stall;
        test_reset_mid;
        test_level_held;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
